// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: drives code-memory addresses, captures 1-cycle-latency read data
// into a {pc,inst} FIFO for decode, squashes on redirect and flags out-of-range fetches.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          DEPTH     = 2,
  parameter int          MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_inst,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int          PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW        = $clog2(DEPTH + 1);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          fault;
  entry_t        fifo_q [DEPTH];
  entry_t        head;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic          pop;
  logic          push;
  logic          issue;
  logic          in_range;

  assign in_range = (fetch_pc < MEM_LIMIT);
  assign pop      = inst_valid & inst_ready & ~redirect;
  assign push     = inflight & ~redirect;

  // Slots already spoken for: buffered entries plus the word still coming back from memory.
  // A pop only happens with count >= 1, so this never underflows.
  assign credit_used = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue       = ~redirect & ~fault & in_range & (credit_used < (CW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fault       <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~32'h3;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fault    <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (~fault & ~in_range) begin
        fault <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_q[wr_ptr] <= '{pc: inflight_pc, inst: mem_inst};
    end
  end

  assign head        = fifo_q[rd_ptr];
  assign inst_valid  = (count != '0);
  assign inst_out    = inst_valid ? head.inst : '0;
  assign pc_out      = inst_valid ? head.pc   : '0;
  assign mem_addr    = fetch_pc;
  assign fetch_fault = fault;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count == CW'(DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(pop && (count == '0)));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized and directed bench for fetch_ctrl, scored against a PC-stream reference model.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam int          DEPTH     = 2;
  localparam int          MEM_BYTES = 1024;
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_inst = '0;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  logic [31:0] exp_pc;
  logic        hold;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;

  fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_inst(mem_inst),
    .inst_out(inst_out), .pc_out(pc_out), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] code_word(input logic [31:0] a);
    if (a < MEM_LIMIT) return 32'hA000_0000 + (a >> 2);
    return 32'hBAD0_0000 ^ a;
  endfunction

  // Synchronous-read code memory
  always @(posedge clk) mem_inst <= code_word(mem_addr);

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, score the handshake against the expected PC stream, advance.
  task automatic tick(input logic rdy, input logic rd, input logic [31:0] rpc, input logic rst);
    inst_ready  = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    reset       = rst;
    if (hold) begin
      check32("stall_valid", 32'(inst_valid), 32'd1);
      check32("stall_pc", pc_out, hold_pc);
      check32("stall_inst", inst_out, hold_inst);
    end
    hold      = inst_valid && !rdy && !rd && !rst;
    hold_pc   = pc_out;
    hold_inst = inst_out;
    if (rst) begin
      exp_pc = RESET_PC;
    end else if (rd) begin
      exp_pc = rpc & ~32'h3;
    end else if (inst_valid && rdy) begin
      check32("pop_pc", pc_out, exp_pc);
      check32("pop_inst", inst_out, code_word(exp_pc));
      check32("pop_range", 32'(pc_out < MEM_LIMIT), 32'd1);
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] hd;
    logic        rdy;
    logic [31:0] rpc;
    int          r;
    int          pops_start;

    inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; reset = 1'b1;
    exp_pc = RESET_PC; hold = 1'b0; hold_pc = '0; hold_inst = '0;
    @(negedge clk);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    check32("rst_valid", 32'(inst_valid), 32'd0);
    check32("rst_inst", inst_out, 32'd0);
    check32("rst_pc", pc_out, 32'd0);
    check32("rst_fault", 32'(fetch_fault), 32'd0);
    check32("rst_addr", mem_addr, RESET_PC);

    // Stream start: valid two cycles after release, one word per cycle
    tick(1, 0, 0, 0);
    check32("start_valid0", 32'(inst_valid), 32'd0);
    check32("start_addr1", mem_addr, RESET_PC + 32'd4);
    tick(1, 0, 0, 0);
    check32("start_valid1", 32'(inst_valid), 32'd1);
    check32("start_pc0", pc_out, RESET_PC);
    check32("start_inst0", inst_out, code_word(RESET_PC));
    check32("start_addr2", mem_addr, RESET_PC + 32'd8);
    tick(1, 0, 0, 0);
    check32("start_pc1", pc_out, RESET_PC + 32'd4);
    tick(1, 0, 0, 0);
    check32("start_pc2", pc_out, RESET_PC + 32'd8);

    // Backpressure: FIFO fills, address freezes
    hd = pc_out;
    repeat (5) begin
      tick(0, 0, 0, 0);
      check32("bp_valid", 32'(inst_valid), 32'd1);
      check32("bp_pc", pc_out, hd);
      check32("bp_addr", mem_addr, hd + 32'(4 * DEPTH));
    end
    repeat (6) tick(1, 0, 0, 0);

    // Redirect mid-stream
    tick(1, 1, 32'h40, 0);
    check32("rd_valid1", 32'(inst_valid), 32'd0);
    check32("rd_addr", mem_addr, 32'h40);
    tick(1, 0, 0, 0);
    check32("rd_valid2", 32'(inst_valid), 32'd0);
    tick(1, 0, 0, 0);
    check32("rd_valid3", 32'(inst_valid), 32'd1);
    check32("rd_pc", pc_out, 32'h40);
    repeat (3) tick(1, 0, 0, 0);

    // Unaligned redirect with a full FIFO
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 32'h47, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check32("ua_valid", 32'(inst_valid), 32'd1);
    check32("ua_pc", pc_out, 32'h44);

    // Back-to-back redirects: the last one wins
    tick(1, 1, 32'h100, 0);
    tick(1, 1, 32'h200, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check32("rr_valid", 32'(inst_valid), 32'd1);
    check32("rr_pc", pc_out, 32'h200);

    // Fault at end of memory
    tick(1, 1, MEM_LIMIT - 32'd8, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check32("ft_pc0", pc_out, MEM_LIMIT - 32'd8);
    check32("ft_fault0", 32'(fetch_fault), 32'd0);
    tick(1, 0, 0, 0);
    check32("ft_pc1", pc_out, MEM_LIMIT - 32'd4);
    check32("ft_fault1", 32'(fetch_fault), 32'd1);
    repeat (4) begin
      tick(1, 0, 0, 0);
      check32("ft_valid", 32'(inst_valid), 32'd0);
      check32("ft_fault", 32'(fetch_fault), 32'd1);
      check32("ft_addr", mem_addr, MEM_LIMIT);
    end
    tick(1, 1, 32'h0, 0);
    check32("ft_clear", 32'(fetch_fault), 32'd0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check32("ft_resume", pc_out, 32'h0);

    // Reset while faulted with two entries buffered
    tick(0, 1, MEM_LIMIT - 32'd8, 0);
    repeat (4) tick(0, 0, 0, 0);
    check32("mr_fault", 32'(fetch_fault), 32'd1);
    check32("mr_head", pc_out, MEM_LIMIT - 32'd8);
    tick(0, 0, 0, 1);
    check32("mr_valid", 32'(inst_valid), 32'd0);
    check32("mr_fault_clr", 32'(fetch_fault), 32'd0);
    check32("mr_addr", mem_addr, RESET_PC);
    tick(1, 0, 0, 0);
    check32("mr_valid1", 32'(inst_valid), 32'd0);
    tick(1, 0, 0, 0);
    check32("mr_pc", pc_out, RESET_PC);

    // Random traffic against the PC-stream model
    for (int i = 0; i < 3000; i++) begin
      r   = int'($urandom_range(0, 99));
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) rpc = 32'($urandom_range(0, MEM_BYTES - 1));
      else rpc = MEM_LIMIT - 32'd32 + 32'($urandom_range(0, 47));
      if (r < 1) tick(rdy, 0, 0, 1);
      else if (r < 4) tick(rdy, 1, rpc, 0);
      else tick(rdy, 0, 0, 0);
    end

    // Throughput: one instruction per cycle once the pipe is primed
    tick(1, 1, 32'h80, 0);
    pops_start = pops;
    repeat (12) tick(1, 0, 0, 0);
    check32("throughput", 32'(pops - pops_start), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
